// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit: funct3 op
// encodings, FSM state encodings and small op-classification helpers.
package muldiv_seq_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // rs1 is treated as two's complement for these ops
  function automatic logic op_a_signed(input op_e op);
    case (op)
      OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: op_a_signed = 1'b1;
      default:                                    op_a_signed = 1'b0;
    endcase
  endfunction

  // rs2 is treated as two's complement for these ops
  function automatic logic op_b_signed(input op_e op);
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: op_b_signed = 1'b1;
      default:                         op_b_signed = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_div(input op_e op);
    case (op)
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: op_is_div = 1'b1;
      default:                          op_is_div = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_rem(input op_e op);
    case (op)
      OP_REM, OP_REMU: op_is_rem = 1'b1;
      default:         op_is_rem = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_seq_div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift the next
// dividend bit into the partial remainder, trial-subtract the divisor and keep
// the difference only when it did not borrow.
module muldiv_seq_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shift_s;
  logic [XLEN:0] diff_s;

  // Trial subtract and select the restored or reduced remainder
  always_comb begin
    shift_s = {rem_i, quo_i[XLEN-1]};
    diff_s  = shift_s - {1'b0, dvs_i};
    if (diff_s[XLEN]) begin
      rem_o = shift_s[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end else begin
      rem_o = diff_s[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit sitting in the execute stage.
// Iterative ops take 33 cycles (1 IDLE accept cycle that also does the first
// iteration, 31 RUN cycles, 1 DONE cycle). Divide-by-zero and signed divide
// overflow finish in 2 cycles.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use one wide signed
// product and finish in 2 cycles; divide is unchanged.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            startE,
  input  logic [2:0]      opE,
  input  logic [XLEN-1:0] aE,
  input  logic [XLEN-1:0] bE,
  input  logic            flushE,
  output logic            stallE,
  output logic            validE,
  output logic [XLEN-1:0] resultE
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 2);
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  op_e             op_q, op_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic [XLEN-1:0] acc_q, acc_d;   // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;     // product low half + multiplier / quotient + dividend
  logic [XLEN-1:0] opnd_q, opnd_d; // multiplicand / divisor magnitude
  logic [XLEN-1:0] res_q, res_d;

  op_e             op_in_s;
  logic            sa_in_s, sb_in_s;
  logic [XLEN-1:0] a_mag_s, b_mag_s;
  logic            div_zero_s, div_ovf_s;

  // Decode the incoming instruction: operand signs, magnitudes, special divides
  always_comb begin
    op_in_s    = op_e'(opE);
    sa_in_s    = op_a_signed(op_in_s) & aE[XLEN-1];
    sb_in_s    = op_b_signed(op_in_s) & bE[XLEN-1];
    a_mag_s    = sa_in_s ? ('0 - aE) : aE;
    b_mag_s    = sb_in_s ? ('0 - bE) : bE;
    div_zero_s = op_is_div(op_in_s) & (bE == '0);
    div_ovf_s  = ((op_in_s == OP_DIV) || (op_in_s == OP_REM)) &&
                 (aE == INT_MIN) && (bE == '1);
  end

  logic            step_div_s;
  logic [XLEN-1:0] step_acc_s, step_lo_s, step_opnd_s;

  // Iteration operands: fresh magnitudes in the accept cycle, running state in RUN
  always_comb begin
    if (state_q == ST_IDLE) begin
      step_div_s  = op_is_div(op_in_s);
      step_acc_s  = '0;
      step_lo_s   = step_div_s ? a_mag_s : b_mag_s;
      step_opnd_s = step_div_s ? b_mag_s : a_mag_s;
    end else begin
      step_div_s  = op_is_div(op_q);
      step_acc_s  = acc_q;
      step_lo_s   = lo_q;
      step_opnd_s = opnd_q;
    end
  end

  logic [XLEN:0]   madd_s;
  logic [XLEN-1:0] mul_acc_s, mul_lo_s;

  // One shift-add multiply iteration: add multiplicand on a set bit, shift right
  always_comb begin
    if (step_lo_s[0]) begin
      madd_s = {1'b0, step_acc_s} + {1'b0, step_opnd_s};
    end else begin
      madd_s = {1'b0, step_acc_s};
    end
    mul_acc_s = madd_s[XLEN:1];
    mul_lo_s  = {madd_s[0], step_lo_s[XLEN-1:1]};
  end

  logic [XLEN-1:0] div_rem_s, div_quo_s;

  muldiv_seq_div_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .rem_i(step_acc_s),
    .quo_i(step_lo_s),
    .dvs_i(step_opnd_s),
    .rem_o(div_rem_s),
    .quo_o(div_quo_s)
  );

  logic [XLEN-1:0]   acc_n_s, lo_n_s;
  logic [2*XLEN-1:0] prod_s, prod_sgn_s;
  logic [XLEN-1:0]   quo_s, rem_s, final_s;

  // Select this iteration's outcome and sign-correct it into the op's result
  always_comb begin
    acc_n_s    = step_div_s ? div_rem_s : mul_acc_s;
    lo_n_s     = step_div_s ? div_quo_s : mul_lo_s;
    prod_s     = {acc_n_s, lo_n_s};
    prod_sgn_s = (sa_q ^ sb_q) ? ('0 - prod_s) : prod_s;
    quo_s      = (sa_q ^ sb_q) ? ('0 - lo_n_s) : lo_n_s;
    rem_s      = sa_q ? ('0 - acc_n_s) : acc_n_s;
    if (op_is_div(op_q)) begin
      final_s = op_is_rem(op_q) ? rem_s : quo_s;
    end else if (op_q == OP_MUL) begin
      final_s = prod_sgn_s[XLEN-1:0];
    end else begin
      final_s = prod_sgn_s[2*XLEN-1:XLEN];
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fa_s, fb_s, fprod_s;
  logic [XLEN-1:0]   fast_s;

  // Single-cycle multiply; each operand is extended according to its signedness
  always_comb begin
    fa_s    = {{XLEN{sa_in_s}}, aE};
    fb_s    = {{XLEN{sb_in_s}}, bE};
    fprod_s = fa_s * fb_s;
    fast_s  = (op_in_s == OP_MUL) ? fprod_s[XLEN-1:0] : fprod_s[2*XLEN-1:XLEN];
  end
`endif

  // Next-state and datapath updates; flush always wins and returns to IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    res_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (flushE) begin
          state_d = ST_IDLE;
        end else if (startE) begin
          op_d   = op_in_s;
          sa_d   = sa_in_s;
          sb_d   = sb_in_s;
          cnt_d  = '0;
          acc_d  = acc_n_s;
          lo_d   = lo_n_s;
          opnd_d = step_opnd_s;
          if (div_zero_s) begin
            res_d   = op_is_rem(op_in_s) ? aE : '1;
            state_d = ST_DONE;
          end else if (div_ovf_s) begin
            res_d   = op_is_rem(op_in_s) ? '0 : INT_MIN;
            state_d = ST_DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!op_is_div(op_in_s)) begin
            res_d   = fast_s;
            state_d = ST_DONE;
          end
`endif
          else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (flushE) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = acc_n_s;
          lo_d  = lo_n_s;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            res_d   = final_s;
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MUL;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
    end
  end

  // Pipeline handshake: stall while accepting or running, present result in DONE
  always_comb begin
    stallE  = 1'b0;
    validE  = 1'b0;
    resultE = '0;
    if (rst || flushE) begin
      stallE  = 1'b0;
      validE  = 1'b0;
      resultE = '0;
    end else begin
      stallE  = ((state_q == ST_IDLE) && startE) || (state_q == ST_RUN);
      validE  = (state_q == ST_DONE);
      resultE = validE ? res_q : '0;
    end
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL expose port clk  input  1  rising-edge clock.
REQ-002 SHALL expose port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL expose port startE  input  1  M-extension instruction is present in execute; held high until it completes.
REQ-004 SHALL expose port opE  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-005 SHALL expose port aE  input  32  forwarded rs1 operand.
REQ-006 SHALL expose port bE  input  32  forwarded rs2 operand.
REQ-007 SHALL expose port flushE  input  1  kill the in-flight operation.
REQ-008 SHALL expose port stallE  output  1  freeze the fetch, decode and execute pipeline registers.
REQ-009 SHALL expose port validE  output  1  resultE holds the completed value this cycle.
REQ-010 SHALL expose port resultE  output  32  result to be muxed into ALUout before the execute/memory register.
REQ-011 SHALL expose parameter XLEN, default 32, meaning operand width.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
- Transitions: IDLE->RUN on startE. RUN->DONE when the iteration counter reaches 31. DONE->IDLE always.
REQ-013 SHALL latch in IDLE on startE: operands, opE, operand signs, and an iteration counter cleared to 0.
REQ-014 SHALL drive stallE = (IDLE & startE & ~flushE) | RUN; stallE SHALL be 0 in DONE.
REQ-015 SHALL drive validE=1 only in DONE, for exactly one cycle; resultE SHALL be stable for that cycle and 0 otherwise.
REQ-016 SHALL ignore startE in DONE, because it is the same instruction; no restart.
REQ-017 SHALL perform multiply as iterative shift-add on 32-bit magnitudes in RUN, one bit per cycle, building a 64-bit product.
- MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- Result is sign-corrected according to the op.
REQ-018 SHALL perform divide as restoring division in RUN, one quotient bit per cycle, on magnitudes.
- Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-019 SHALL give latency from the first startE cycle to validE of 33 cycles: 1 IDLE, 31 RUN, 1 DONE.
REQ-020 SHALL handle divide by zero (b=0) by going IDLE->DONE directly.
- DIV/DIVU return 0xFFFFFFFF; REM/REMU return a.
REQ-021 SHALL handle signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF) by going IDLE->DONE directly.
- DIV returns 0x80000000; REM returns 0.
REQ-022 SHALL make flushE force the next state to IDLE from any state, with no validE and stallE=0 in that cycle.
REQ-023 SHALL give flushE priority over startE when both are asserted.

Reset
REQ-024 SHALL on rst force state IDLE and clear the counter, operand and result registers, with stallE=0, validE=0, resultE=0.
REQ-025 SHALL abandon any in-progress operation on rst, even mid-RUN, with no validE afterwards.

Configuration
REQ-026 SHALL, with MULDIV_FAST_MUL_EN defined, compute multiplies as a single 33x33 signed product.
- Sequence is IDLE->DONE, latency 2 cycles.
- Divide is unchanged.
REQ-027 SHALL, without MULDIV_FAST_MUL_EN, use the iterative multiply per REQ-017 and REQ-019.

Structure
REQ-028 SHALL place the funct3 op encodings and the FSM state encodings in the shared include header used by the alu and the decoder.
REQ-029 SHALL implement one restoring-division step (remainder/quotient shift, trial subtract, select) as sub-module div_step, instantiated once.

Verification
REQ-030 MUL: a=7, b=-3 -> validE 33 cycles after start, resultE=0xFFFFFFEB; stallE high for 32 cycles.
REQ-031 MULHU: a=0xFFFFFFFF, b=0xFFFFFFFF -> resultE=0xFFFFFFFE.
- With MULDIV_FAST_MUL_EN: same value, validE at cycle 2.
REQ-032 DIV: a=-20, b=3 -> resultE=0xFFFFFFFA (-6).
- REM with the same operands -> resultE=0xFFFFFFFE (-2).
REQ-033 DIVU: a=5, b=0 -> resultE=0xFFFFFFFF at cycle 2.
- DIV: a=0x80000000, b=-1 -> resultE=0x80000000 at cycle 2.
REQ-034 Flush and reset mid-operation:
- flushE at RUN cycle 10 -> next cycle IDLE, stallE=0, no validE.
- rst at RUN cycle 5 -> all outputs 0 immediately.
REQ-035 Back-to-back: DIVU(100,7) then MUL(6,7) with startE continuous across DONE -> resultE 14, then 42; the second op starts only after one DONE cycle.
